traceback_lifo_reorder: RTL and testbench
=========================================

Name: traceback_lifo_reorder

Overview:
- Consumer end of the survivor-path traceback output interface of the Viterbi decoder.
- Accepts the time-reversed decoded bit stream (one bit per clock) together with a block-boundary toggle.
- Buffers each block in one of two ping-pong LIFO banks and replays it in forward order during the following block.
- Emits a forward-ordered decoded bit stream with a valid strobe and a block-start marker.

Parameters:
- BLOCK_LEN, 21, nominal bits per traceback block; legal range 2..32; sets bank depth.
- SKIP_BLOCKS, 2, number of completed blocks discarded after reset (traceback warm-up garbage); legal range 0..15.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- reverse_decoded_bit  input  1  time-reversed decoded bit, valid every cycle.
- stack_toggle  input  1  inverts once per block; either edge marks a block boundary.
- decoded_bit_out  output  1  forward-ordered decoded bit.
- decoded_valid_out  output  1  decoded_bit_out valid this cycle.
- frame_start_out  output  1  high with the first valid bit of each emitted block.
- drop_out  output  1  one-cycle pulse when unread bits of a block are abandoned.
- overflow_out  output  1  sticky flag: more than BLOCK_LEN bits arrived in one block.

Behaviour:
- Reset (reset_n low at rising edge):
  - all outputs 0; toggle_q 0; write bank 0; wr_cnt 0; rd_rem 0; skip_cnt SKIP_BLOCKS.
  - Bank contents are don't-care.
- Boundary detect: toggle_q registers stack_toggle every cycle; boundary edge E = a rising clk edge where stack_toggle != toggle_q.
- Write side:
  - Every edge writes reverse_decoded_bit into the write bank at wr_cnt; wr_cnt increments.
  - At an edge E, the incoming bit is the first bit of the new block. It goes to index 0 of the newly selected bank, and wr_cnt becomes 1.
  - Bits arriving before the first E after reset form block 0.
- Overflow: if wr_cnt == BLOCK_LEN and no boundary, the bit is dropped, wr_cnt holds and overflow_out sets. overflow_out clears only on reset.
- Boundary at E (n = wr_cnt of the completed block, 1..BLOCK_LEN):
  - Swap banks.
  - If skip_cnt == 0: rd_ptr <= n-1 and rd_rem <= n.
  - Else: skip_cnt decrements and the completed block is discarded (rd_rem <= 0).
- Read side, each edge with rd_rem > 0:
  - decoded_bit_out <= read_bank[rd_ptr]; decoded_valid_out <= 1.
  - rd_ptr decrements; rd_rem decrements.
  - frame_start_out <= 1 only on the first read of a block.
  - Otherwise decoded_valid_out and frame_start_out are 0; decoded_bit_out holds its last value.
- Latency:
  - Block bits appear at outputs in the n cycles following edges E+1..E+n.
  - Output order: last-received bit first, i.e. index n-1 down to 0.
  - With nominal 21-cycle blocks, output is continuous: 21 valid cycles per block, no gaps.
- Simultaneous events:
  - Read-before-write: a read and a write of the same bank index at the same edge return the old data.
  - Boundary at E' while rd_rem > 0: the read at E' is still performed from the old contents. If rd_rem > 1 before that read, the remaining reads are abandoned and drop_out pulses in the cycle after E'. The new block then loads as above.
  - Short block (n < BLOCK_LEN) emits exactly n bits.
- Reset mid-read aborts all activity immediately; outputs go to their reset values the next cycle.

Optional Feature:
- Macro: DECODED_BYTE_PACK_EN.
- When defined, adds two ports:
  - byte_out  output  8
  - byte_valid_out  output  1
- Packing rules:
  - Valid output bits are packed LSB-first: the first bit goes to byte_out[0].
  - byte_valid_out pulses one cycle after each 8th bit, with byte_out updated in that same cycle.
  - Packing runs continuously across block boundaries and is not realigned per block.
  - Dropped bits are not packed.
  - Reset clears the partial byte; byte_out and byte_valid_out reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Warm-up skip:
  - Stimulus: SKIP_BLOCKS=2; toggle every 21 cycles; input bits = index pattern.
  - Required: no decoded_valid_out for the first 2 boundaries; from the 3rd boundary on, 21 valid cycles per block, frame_start_out high on the first of each.
- Order reversal:
  - Stimulus: block bits received as 1,0,0,...,0 (first bit 1).
  - Required: emitted 0 × 20, then 1 as the 21st valid bit; back-to-back blocks give gapless valid.
- Short block:
  - Stimulus: a toggle 5 cycles after the previous toggle, with bits 1,1,0,1,0.
  - Required: exactly 5 valid outputs 0,1,0,1,1; no drop_out.
- Early boundary:
  - Stimulus: a 21-bit block is being read; a new toggle arrives after 10 reads.
  - Required: the 11th read still occurs; drop_out pulses once; the next block starts with frame_start_out.
- Overflow and reset:
  - Stimulus: 25 cycles without a toggle.
  - Required: overflow_out sets at the 22nd bit and stays set; that block emits 21 bits; asserting reset_n low mid-read clears all outputs and overflow_out the next cycle.
- DECODED_BYTE_PACK_EN:
  - Stimulus: a 21-bit block that emits forward bits 1,0,1,1,0,0,0,0 first.
  - Required: byte_out = 8'h0D with byte_valid_out a single-cycle pulse; the 3rd byte of the stream straddles the block boundary.

Source files
------------

// File: rtl/traceback_lifo_reorder.sv
// Ping-pong LIFO that turns time-reversed Viterbi traceback bits back into forward order.
// Optional LSB-first byte packer on the output stream, enabled by DECODED_BYTE_PACK_EN.
module traceback_lifo_reorder #(
    parameter int unsigned BLOCK_LEN   = 21,
    parameter int unsigned SKIP_BLOCKS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       reverse_decoded_bit,
    input  logic       stack_toggle,
    output logic       decoded_bit_out,
    output logic       decoded_valid_out,
    output logic       frame_start_out,
    output logic       drop_out,
    output logic       overflow_out
`ifdef DECODED_BYTE_PACK_EN
    ,
    output logic [7:0] byte_out,
    output logic       byte_valid_out
`endif
);
    localparam int unsigned CNT_W  = $clog2(BLOCK_LEN + 1);
    localparam int unsigned PTR_W  = $clog2(BLOCK_LEN);
    localparam int unsigned SKIP_W = 4;

    logic                      toggle_q,   toggle_d;
    logic                      wr_bank_q,  wr_bank_d;
    logic [CNT_W-1:0]          wr_cnt_q,   wr_cnt_d;
    logic [1:0][BLOCK_LEN-1:0] bank_q,     bank_d;
    logic [PTR_W-1:0]          rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]          rd_rem_q,   rd_rem_d;
    logic                      first_q,    first_d;
    logic [SKIP_W-1:0]         skip_cnt_q, skip_cnt_d;
    logic                      dbit_q,     dbit_d;
    logic                      valid_q,    valid_d;
    logic                      frame_q,    frame_d;
    logic                      drop_q,     drop_d;
    logic                      ovf_q,      ovf_d;
    logic                      boundary;
    logic                      rd_bank;

    // Read the bank not being written; a boundary swaps roles, so the old read happens first.
    always_comb begin
        toggle_d   = stack_toggle;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        bank_d     = bank_q;
        rd_ptr_d   = rd_ptr_q;
        rd_rem_d   = rd_rem_q;
        first_d    = first_q;
        skip_cnt_d = skip_cnt_q;
        dbit_d     = dbit_q;
        valid_d    = 1'b0;
        frame_d    = 1'b0;
        drop_d     = 1'b0;
        ovf_d      = ovf_q;
        boundary   = (stack_toggle != toggle_q);
        rd_bank    = ~wr_bank_q;

        if (rd_rem_q != '0) begin
            dbit_d   = bank_q[rd_bank][rd_ptr_q];
            valid_d  = 1'b1;
            frame_d  = first_q;
            first_d  = 1'b0;
            rd_ptr_d = rd_ptr_q - PTR_W'(1);
            rd_rem_d = rd_rem_q - CNT_W'(1);
        end

        if (boundary) begin
            wr_bank_d           = rd_bank;
            bank_d[rd_bank][0]  = reverse_decoded_bit;
            wr_cnt_d            = CNT_W'(1);
            drop_d              = (rd_rem_q > CNT_W'(1));
            if (skip_cnt_q == '0) begin
                rd_ptr_d = PTR_W'(wr_cnt_q - CNT_W'(1));
                rd_rem_d = wr_cnt_q;
                first_d  = 1'b1;
            end else begin
                skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                rd_rem_d   = '0;
            end
        end else if (wr_cnt_q < CNT_W'(BLOCK_LEN)) begin
            bank_d[wr_bank_q][PTR_W'(wr_cnt_q)] = reverse_decoded_bit;
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            toggle_q   <= 1'b0;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            bank_q     <= '0;
            rd_ptr_q   <= '0;
            rd_rem_q   <= '0;
            first_q    <= 1'b0;
            skip_cnt_q <= SKIP_W'(SKIP_BLOCKS);
            dbit_q     <= 1'b0;
            valid_q    <= 1'b0;
            frame_q    <= 1'b0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            toggle_q   <= toggle_d;
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            bank_q     <= bank_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_rem_q   <= rd_rem_d;
            first_q    <= first_d;
            skip_cnt_q <= skip_cnt_d;
            dbit_q     <= dbit_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
        end
    end

    assign decoded_bit_out   = dbit_q;
    assign decoded_valid_out = valid_q;
    assign frame_start_out   = frame_q;
    assign drop_out          = drop_q;
    assign overflow_out      = ovf_q;

`ifdef DECODED_BYTE_PACK_EN
    logic [6:0] pk_q,       pk_d;
    logic [2:0] pk_cnt_q,   pk_cnt_d;
    logic [7:0] byte_q,     byte_d;
    logic       byte_vld_q, byte_vld_d;

    // Packs the registered output stream, so a byte lands one cycle after its 8th bit.
    always_comb begin
        pk_d       = pk_q;
        pk_cnt_d   = pk_cnt_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        if (valid_q) begin
            if (pk_cnt_q == 3'd7) begin
                byte_d     = {dbit_q, pk_q};
                byte_vld_d = 1'b1;
            end else begin
                pk_d[pk_cnt_q] = dbit_q;
            end
            pk_cnt_d = pk_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pk_q       <= '0;
            pk_cnt_q   <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
        end else begin
            pk_q       <= pk_d;
            pk_cnt_q   <= pk_cnt_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
        end
    end

    assign byte_out       = byte_q;
    assign byte_valid_out = byte_vld_q;
`endif

endmodule

// File: tb/tb_traceback_lifo_reorder.sv
// Scoreboard bench for traceback_lifo_reorder; expected bits are queued with the cycle they must appear.
module tb_traceback_lifo_reorder;
    localparam int BLOCK_LEN   = 21;
    localparam int SKIP_BLOCKS = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic reverse_decoded_bit = 1'b0;
    logic stack_toggle = 1'b0;
    logic decoded_bit_out, decoded_valid_out, frame_start_out, drop_out, overflow_out;
`ifdef DECODED_BYTE_PACK_EN
    logic [7:0] byte_out;
    logic       byte_valid_out;
`endif

    traceback_lifo_reorder #(.BLOCK_LEN(BLOCK_LEN), .SKIP_BLOCKS(SKIP_BLOCKS)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .reverse_decoded_bit (reverse_decoded_bit),
        .stack_toggle        (stack_toggle),
        .decoded_bit_out     (decoded_bit_out),
        .decoded_valid_out   (decoded_valid_out),
        .frame_start_out     (frame_start_out),
        .drop_out            (drop_out),
        .overflow_out        (overflow_out)
`ifdef DECODED_BYTE_PACK_EN
        ,
        .byte_out            (byte_out),
        .byte_valid_out      (byte_valid_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   stamp;
        logic b;
        logic fr;
    } exp_t;

    exp_t q[$];
    int   dq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic rst_edge = 1'b1;

    // Driver-side reference state
    logic [31:0] cur_blk = '0;
    int          cnt_m = 0;
    int          skip_m = SKIP_BLOCKS;
    bit          started = 1'b0;
    int          ovf_set = -1;
    int          ovf_clr = -1;

`ifdef DECODED_BYTE_PACK_EN
    typedef struct {
        int         stamp;
        logic [7:0] v;
    } byt_t;
    byt_t       bq[$];
    logic [7:0] pk_exp = '0;
    int         pk_n = 0;
    bit         want_0d = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic ovf_exp(input int c);
        return (ovf_set >= 0) && (c >= ovf_set) && !((ovf_clr > ovf_set) && (c >= ovf_clr));
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_edge = !reset_n;
    end

    always @(negedge clk) begin : mon
        exp_t e;
        logic exp_v;
        logic exp_d;
        if (rst_edge) begin
            chk("rst_bit",   32'(decoded_bit_out),   32'd0);
            chk("rst_valid", 32'(decoded_valid_out), 32'd0);
            chk("rst_frame", 32'(frame_start_out),   32'd0);
            chk("rst_drop",  32'(drop_out),          32'd0);
            chk("rst_ovf",   32'(overflow_out),      32'd0);
            q.delete();
            dq.delete();
`ifdef DECODED_BYTE_PACK_EN
            chk("rst_byte",  32'(byte_out),       32'd0);
            chk("rst_bvld",  32'(byte_valid_out), 32'd0);
            bq.delete();
            pk_n = 0;
`endif
        end else begin
            exp_v = (q.size() > 0) && (q[0].stamp <= cyc);
            chk("valid", 32'(decoded_valid_out), 32'(exp_v));
            if (exp_v) begin
                e = q.pop_front();
                if (decoded_valid_out) begin
                    chk("bit",   32'(decoded_bit_out), 32'(e.b));
                    chk("frame", 32'(frame_start_out), 32'(e.fr));
                end
`ifdef DECODED_BYTE_PACK_EN
                pk_exp[pk_n] = e.b;
                pk_n++;
                if (pk_n == 8) begin
                    bq.push_back('{stamp: cyc + 1, v: pk_exp});
                    pk_n = 0;
                end
`endif
            end else begin
                chk("frame_idle", 32'(frame_start_out), 32'd0);
            end
            exp_d = (dq.size() > 0) && (dq[0] <= cyc);
            chk("drop", 32'(drop_out), 32'(exp_d));
            if (exp_d) void'(dq.pop_front());
            chk("overflow", 32'(overflow_out), 32'(ovf_exp(cyc)));
`ifdef DECODED_BYTE_PACK_EN
            begin
                byt_t bb;
                logic exp_b;
                exp_b = (bq.size() > 0) && (bq[0].stamp <= cyc);
                chk("byte_valid", 32'(byte_valid_out), 32'(exp_b));
                if (exp_b) begin
                    bb = bq.pop_front();
                    if (byte_valid_out) begin
                        chk("byte", 32'(byte_out), 32'(bb.v));
                        if (want_0d) begin
                            chk("byte_first", 32'(byte_out), 32'h0D);
                            want_0d = 1'b0;
                        end
                    end
                end
            end
`endif
        end
    end

    // A completed block of n bits is replayed newest-first on edges e+1..e+n.
    task automatic close_block(input int e);
        int n;
        bit tr;
        exp_t x;
        n  = cnt_m;
        tr = 1'b0;
        while (q.size() > 0 && q[$].stamp > e) begin
            void'(q.pop_back());
            tr = 1'b1;
        end
        if (tr) dq.push_back(e);
        if (skip_m == 0) begin
            for (int j = 1; j <= n; j++) begin
                x.stamp = e + j;
                x.b     = cur_blk[n - j];
                x.fr    = (j == 1);
                q.push_back(x);
            end
        end else begin
            skip_m--;
        end
    endtask

    task automatic drive_bit(input logic b, input logic flip);
        int e;
        @(posedge clk);
        #1;
        e = cyc + 1;
        reset_n = 1'b1;
        if (flip) begin
            stack_toggle = ~stack_toggle;
            close_block(e);
            cnt_m = 0;
        end
        reverse_decoded_bit = b;
        if (cnt_m < BLOCK_LEN) begin
            cur_blk[cnt_m] = b;
            cnt_m++;
        end else if (!((ovf_set >= 0) && (ovf_set > ovf_clr))) begin
            ovf_set = e;
        end
    endtask

    task automatic send_block(input int len, input logic [31:0] pat);
        for (int i = 0; i < len; i++) begin
            drive_bit(pat[i], (i == 0) && started);
            started = 1'b1;
        end
    endtask

    task automatic apply_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            reset_n = 1'b0;
            stack_toggle = 1'b0;
            reverse_decoded_bit = 1'b0;
            if (i == 0) ovf_clr = cyc + 1;
        end
        cnt_m   = 0;
        skip_m  = SKIP_BLOCKS;
        started = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] pat;
        apply_reset(3);

        // Warm-up blocks are discarded, then steady 21-bit blocks
        for (int b = 0; b < 5; b++) send_block(21, $urandom);

        // First received bit 1, rest 0: the 1 must come out last
        pat = 32'h0000_0001;
        send_block(21, pat);
        send_block(21, pat);

        // Short block: received 1,1,0,1,0 comes out 0,1,0,1,1
        pat = 32'b01011;
        send_block(5, pat);
        send_block(21, $urandom);

        // Early boundary after 10 reads of a full block
        send_block(11, $urandom);
        send_block(21, $urandom);

        // Overflow, then reset while a block is being read
        send_block(25, $urandom);
        send_block(21, $urandom);
        send_block(8, $urandom);
        apply_reset(2);

        // Fresh stream: third block emits 1,0,1,1,0,0,0,0 first
`ifdef DECODED_BYTE_PACK_EN
        want_0d = 1'b1;
`endif
        send_block(21, $urandom);
        send_block(21, $urandom);
        pat = $urandom;
        pat[20:13] = 8'b1011_0000;
        send_block(21, pat);
        send_block(21, $urandom);
        send_block(21, $urandom);
        for (int i = 0; i < 25; i++) drive_bit($urandom_range(0, 1) == 1, 1'b0);
        @(posedge clk);
        @(negedge clk);

        chk("exp_bits_left", 32'(q.size()), 32'd0);
        chk("exp_drops_left", 32'(dq.size()), 32'd0);
`ifdef DECODED_BYTE_PACK_EN
        chk("exp_bytes_left", 32'(bq.size()), 32'd0);
        chk("first_byte_seen", 32'(want_0d), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
